shared_timer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one down-counting interval timer among NREQ requesters. Each requester asks for a delay. The block grants the timer to one requester at a time, loads that requester's delay, and counts it out. It then returns a one-cycle completion pulse and moves on to the next requester. The block sits between multiple control FSMs and the counter resource, replacing per-client free-running ripple counters with a single scheduled counter.

---
 rtl/shared_timer_arbiter.sv | 116 +++++++++++
 tb/tb_shared_timer_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_timer_arbiter.sv
// Round-robin sequencer sharing one down-counting interval timer among NREQ
// requesters; each grant counts out the winner's delay, then pulses done.
module shared_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_delay,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      count
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;

  logic            found;
  logic [IW-1:0]   win;
  int              j;

  // Search starts just past the previous winner so every pending requester
  // gets a turn before anyone is served twice.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(last_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = RUN;
          owner_d      = win;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          busy_d       = 1'b1;
          count_d      = req_delay[win*CW +: CW];
        end
      end
      RUN: begin
        // Abort outranks expiry: a dropped request never sees a done pulse.
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
          last_d  = owner_q;
        end else if (count_q == '0) begin
          state_d         = DONE;
          gnt_d           = '0;
          busy_d          = 1'b0;
          done_d[owner_q] = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed scenarios plus a randomized run scored against a timeline-based
// model of grant start edge, delay and round-robin order.
module tb_shared_timer_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] req_delay;
  logic [N-1:0] gnt, done;
  logic         busy;
  logic [W-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_timer_arbiter #(.NREQ(N), .CW(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_delay(req_delay),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_dly(input int i, input int d);
    req_delay[i*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_delay = {$urandom, $urandom} & {N*W{1'b1}};
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_dly(2, 5); req = 4'b0100;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (gnt !== 4'b0100 || busy !== 1'b1 || done !== 4'b0000) begin
        errors++; $display("FAIL single_gnt[%0d]: gnt %b busy %b done %b want 0100/1/0000", i, gnt, busy, done); end
      checks++; if (count !== W'(5 - i)) begin errors++; $display("FAIL single_count[%0d]: got %0d want %0d", i, count, 5 - i); end
      tick();
    end
    checks++; if (gnt !== 4'b0000 || done !== 4'b0100 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: gnt %b done %b busy %b want 0000/0100/0", gnt, done, busy); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL single_after: gnt %b done %b busy %b count %0d want all zero", gnt, done, busy, count); end
    tick();
  endtask

  task automatic test_zero_delay();
    set_dly(0, 0); req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || count !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_gnt: gnt %b count %0d busy %b want 0001/0/1", gnt, count, busy); end
    tick();
    checks++; if (gnt !== 4'b0000 || done !== 4'b0001) begin
      errors++; $display("FAIL zero_done: gnt %b done %b want 0000/0001", gnt, done); end
    req = 4'b0000;
    tick();
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL zero_pulse: done %b want 0000", done); end
    tick();
  endtask

  task automatic test_fairness();
    int n, prev;
    logic [N-1:0] pg;
    logic [N-1:0] want;
    n = 0; prev = 0; pg = '0;
    do_reset();
    for (int i = 0; i < N; i++) set_dly(i, 2);
    req = 4'b1111;
    for (int t = 0; t < 80 && n < 6; t++) begin
      tick();
      checks++; if (gnt !== 4'b0000 && done !== 4'b0000) begin
        errors++; $display("FAIL fair_overlap: gnt %b done %b", gnt, done); end
      if (gnt !== 4'b0000 && pg === 4'b0000) begin
        want = 4'b0001 << (n % N);
        checks++; if (gnt !== want) begin errors++; $display("FAIL fair_order[%0d]: got %b want %b", n, gnt, want); end
        if (n > 0) begin
          checks++; if (t - prev != 5) begin errors++; $display("FAIL fair_gap[%0d]: got %0d want 5", n, t - prev); end
        end
        prev = t; n++;
      end
      pg = gnt;
    end
    checks++; if (n < 6) begin errors++; $display("FAIL fair_timeout: saw %0d grants want 6", n); end
    req = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_abort();
    int t;
    logic seen_done;
    seen_done = 1'b0;
    do_reset();
    set_dly(1, 10); set_dly(3, 3); req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010 || count !== 8'd10) begin
      errors++; $display("FAIL abort_first: gnt %b count %0d want 0010/10", gnt, count); end
    t = 0;
    while (count !== 8'd4 && t < 30) begin
      if (done !== 4'b0000) seen_done = 1'b1;
      tick(); t++;
    end
    checks++; if (count !== 8'd4) begin errors++; $display("FAIL abort_wait: count %0d want 4", count); end
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 8'd0) begin
      errors++; $display("FAIL abort_clear: gnt %b busy %b done %b count %0d want 0/0/0/0", gnt, busy, done, count); end
    tick();
    checks++; if (gnt !== 4'b1000 || count !== 8'd3 || seen_done) begin
      errors++; $display("FAIL abort_next: gnt %b count %0d stray_done %b want 1000/3/0", gnt, count, seen_done); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    int t;
    do_reset();
    set_dly(3, 7); req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000 || count !== 8'd7) begin
      errors++; $display("FAIL rstmid_first: gnt %b count %0d want 1000/7", gnt, count); end
    t = 0;
    while (count !== 8'd3 && t < 20) begin tick(); t++; end
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0000 || count !== 8'd0 || done !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: gnt %b count %0d done %b busy %b want zeros", gnt, count, done, busy); end
    rst = 1'b0; set_dly(0, 2); req = 4'b1001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_prio: gnt %b want 0001", gnt); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_delay_change();
    int n;
    n = 0;
    set_dly(2, 6); req = 4'b0100;
    tick();
    while (gnt === 4'b0100 && n < 20) begin
      if (n == 1) set_dly(2, 1);
      n++; tick();
    end
    checks++; if (n != 7) begin errors++; $display("FAIL dlychg_len: got %0d grant cycles want 7", n); end
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL dlychg_done: done %b want 0100", done); end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    int m_owner, m_dn, m_last, m_k, m_d, e, w;
    bit fnd;
    logic [N-1:0] eg, ed;
    logic [W-1:0] ec;
    m_owner = -1; m_dn = -1; m_last = N - 1; m_k = 0; m_d = 0; e = 0;
    rst = 1'b1; req = '0;
    for (int c = 0; c < 3000; c++) begin
      // Advance the model using the inputs the coming edge will sample.
      e++;
      if (rst) begin
        m_owner = -1; m_dn = -1; m_last = N - 1;
      end else if (m_dn >= 0) begin
        m_last = m_dn; m_dn = -1;
      end else if (m_owner >= 0) begin
        if (!req[m_owner]) begin m_last = m_owner; m_owner = -1; end
        else if (e - m_k == m_d + 1) begin m_dn = m_owner; m_owner = -1; end
      end else begin
        fnd = 1'b0; w = 0;
        for (int i = 1; i <= N; i++)
          if (!fnd && req[(m_last + i) % N]) begin fnd = 1'b1; w = (m_last + i) % N; end
        if (fnd) begin m_owner = w; m_k = e; m_d = int'(req_delay[w*W +: W]); end
      end
      tick();
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ed = (m_dn >= 0) ? (4'b0001 << m_dn) : 4'b0000;
      ec = (m_owner >= 0) ? W'(m_d - (e - m_k)) : 8'd0;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt, eg); end
      checks++; if (done !== ed) begin errors++; $display("FAIL rnd_done[%0d]: got %b want %b", c, done, ed); end
      checks++; if (count !== ec) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, ec); end
      checks++; if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, m_owner >= 0); end
      rst = ($urandom_range(199) == 0);
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
      if ($urandom_range(2) == 0) set_dly(int'($urandom_range(N - 1)), int'($urandom_range(6)));
    end
    rst = 1'b0; req = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_delay = '0;
    test_reset();
    test_single();
    test_zero_delay();
    test_fairness();
    test_abort();
    test_reset_mid_run();
    test_delay_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
